fifo_byte_packer: RTL and testbench
===================================

# fifo_byte_packer

Read-side consumer for `fifo_simple`. It drains 8-bit entries through the FIFO's `read`/`empty`/`read_data` port and packs them little-endian into 32-bit words. Each word leaves on a valid/ready stream. A partial word is flushed after an idle timeout, so a short burst never stalls in the packer. The block sits directly behind `fifo_simple` on the same clock and feeds the downstream word-wide datapath.

## Interface

Parameters:
- `FIFO_DATA_WIDTH`, default 8: width of one FIFO entry; also the byte-lane width.
- `LANES`, default 4: entries packed per output word; `out_data` is `LANES*FIFO_DATA_WIDTH` bits wide.
- `TIMEOUT`, default 16: idle cycles (FIFO empty, partial word held) before a partial flush; legal range is 2 or more.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `fifo_empty`, input, 1: the FIFO's `empty` flag.
- `fifo_read_data`, input, `FIFO_DATA_WIDTH`: the FIFO head entry; valid whenever `fifo_empty` = 0.
- `fifo_read`, output, 1: pops the FIFO head at the rising edge where it is high.
- `out_valid`, output, 1: `out_data` and `out_count` hold a word.
- `out_ready`, input, 1: downstream accepts the word.
- `out_data`, output, `LANES*FIFO_DATA_WIDTH`: packed word; lane 0 is in bits [7:0] and holds the oldest byte.
- `out_count`, output, `$clog2(LANES)+1`: number of valid lanes, 1..`LANES`.

## Operation

FIFO contract:
- Show-ahead: `fifo_read_data` is the head entry in the same cycle that `fifo_empty` = 0.
- The pop takes effect at the rising edge that samples `fifo_read` = 1.

State machine, two states:
- **FILL**
  - `fifo_read = !fifo_empty && !reset`; this is the only combinational output.
  - On each pop, the byte is written into lane `byte_cnt`, `byte_cnt` increments and `idle_cnt` clears.
  - When the pop fills the last lane (`byte_cnt` becomes `LANES`), go to SEND.
  - If `byte_cnt` > 0 and `fifo_empty` = 1, `idle_cnt` increments. When `idle_cnt` reaches `TIMEOUT-1` and the FIFO is still empty, go to SEND with a partial word.
  - If `byte_cnt` = 0, `idle_cnt` is held at 0. An empty packer never emits a word.
- **SEND**
  - `out_valid` = 1 and `fifo_read` = 0.
  - `out_data` and `out_count` stay stable until the handshake.
  - On `out_valid && out_ready`: clear `byte_cnt`, `idle_cnt` and all lanes to 0, then return to FILL.

Data rules:
- Lanes above `out_count` read as 0.
- `out_count` equals `byte_cnt` at the moment SEND is entered.
- `byte_cnt` never exceeds `LANES`; no pop occurs in SEND, so overflow is impossible.
- If a byte arrives on the same edge that the timeout would fire, the pop wins: the byte is packed, `idle_cnt` clears and the state stays FILL unless that byte filled the last lane.

Reset:
- Applies in any state, including mid-word and mid-SEND.
- Partial data is discarded and not emitted.
- After reset: state FILL, `byte_cnt` = 0, `idle_cnt` = 0.
- Output values: `out_valid` = 0, `out_data` = 0, `out_count` = 0, and `fifo_read` = 0 for as long as `reset` is high.

## Timing

- Full word: the last pop happens at edge N; `out_valid` rises in the cycle after edge N.
- Steady-state throughput with `out_ready` tied high is `LANES` bytes per `LANES+1` cycles (one SEND cycle per word).
- Partial word: the last pop happens at edge N. The FIFO then stays empty and `idle_cnt` counts 0..`TIMEOUT-1`. `out_valid` rises `TIMEOUT` cycles after edge N.
- Backpressure: while `out_ready` = 0, SEND holds indefinitely and `fifo_read` stays 0, so the FIFO may fill. `full` is the FIFO's concern, not the packer's.
- Registered outputs: `out_valid`, `out_data`, `out_count`.
- `fifo_read` is combinational from state, `fifo_empty` and `reset`; it has no input-to-output path through `out_ready`.

## Test plan

- **Reset:** hold `reset` 2 cycles with the FIFO non-empty -> `fifo_read` = 0, `out_valid` = 0, `out_data` = 0 throughout reset; the first pop happens on the first edge after release.
- **Full words:** write 0x00..0x07 into a `fifo_simple` with depth 4, `out_ready` = 1 -> words 0x03020100 then 0x07060504, `out_count` = 4 each; 8 pops in total, with no pop during either SEND cycle.
- **Timeout flush:** write 0x10, 0x11, 0x12, then leave the FIFO empty -> after `TIMEOUT` (16) idle cycles, `out_data` = 0x00121110 with `out_count` = 3. No word is emitted before that point.
- **Backpressure:** hold `out_ready` = 0 for 10 cycles while the FIFO holds 0x20..0x27 -> word 0x23222120 is held stable with `fifo_read` = 0 and the FIFO reaches `full`. On release, the next word is 0x27262524 and no bytes are lost or duplicated.
- **Timeout race:** a byte arrives exactly on the edge where `idle_cnt` = `TIMEOUT-1` -> that byte is packed into the current word and the timeout restarts; no early flush.
- **Reset mid-word:** pop 2 bytes, assert `reset` for 1 cycle, then write 0x30..0x33 -> the next output is 0x33323130 with `out_count` = 4, and the stale bytes never appear.

Source files
------------

// File: rtl/fifo_byte_packer.sv
// fifo_byte_packer: drains a show-ahead FIFO and packs entries little-endian into words,
// flushing a partial word once the FIFO has stayed empty for TIMEOUT cycles.
module fifo_byte_packer #(
   parameter int FIFO_DATA_WIDTH = 8,
   parameter int LANES           = 4,
   parameter int TIMEOUT         = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             fifo_empty,
   input  logic [FIFO_DATA_WIDTH-1:0]       fifo_read_data,
   output logic                             fifo_read,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [LANES*FIFO_DATA_WIDTH-1:0] out_data,
   output logic [$clog2(LANES):0]           out_count
);
   localparam int CW = $clog2(LANES) + 1;
   localparam int IW = $clog2(TIMEOUT);
   typedef enum logic {FILL, SEND} state_t;
   state_t                           r_state, w_state_nxt;
   logic [CW-1:0]                    r_byte_cnt, w_byte_cnt_nxt;
   logic [IW-1:0]                    r_idle_cnt, w_idle_cnt_nxt;
   logic [LANES*FIFO_DATA_WIDTH-1:0] r_data, w_data_nxt;
   logic                             w_pop;
   assign w_pop     = (r_state == FILL) && !fifo_empty;
   assign fifo_read = w_pop && !reset;
   assign out_valid = (r_state == SEND);
   assign out_data  = r_data;
   assign out_count = r_byte_cnt;
   // A pop on the timeout edge wins: the byte is packed and the idle count restarts.
   always_comb begin
      w_state_nxt    = r_state;
      w_byte_cnt_nxt = r_byte_cnt;
      w_idle_cnt_nxt = r_idle_cnt;
      w_data_nxt     = r_data;
      if (r_state == SEND) begin
         if (out_ready) begin
            w_state_nxt    = FILL;
            w_byte_cnt_nxt = '0;
            w_idle_cnt_nxt = '0;
            w_data_nxt     = '0;
         end
      end else if (w_pop) begin
         for (int l = 0; l < LANES; l++)
            if (r_byte_cnt == CW'(l)) w_data_nxt[l*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH] = fifo_read_data;
         w_byte_cnt_nxt = r_byte_cnt + 1'b1;
         w_idle_cnt_nxt = '0;
         w_state_nxt    = (r_byte_cnt == CW'(LANES-1)) ? SEND : FILL;
      end else if (r_byte_cnt != '0) begin
         w_state_nxt    = (r_idle_cnt == IW'(TIMEOUT-1)) ? SEND : FILL;
         w_idle_cnt_nxt = (r_idle_cnt == IW'(TIMEOUT-1)) ? r_idle_cnt : r_idle_cnt + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= FILL;
         r_byte_cnt <= '0;
         r_idle_cnt <= '0;
         r_data     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_byte_cnt <= w_byte_cnt_nxt;
         r_idle_cnt <= w_idle_cnt_nxt;
         r_data     <= w_data_nxt;
      end
   end
endmodule

// File: tb/tb_fifo_byte_packer.sv
// tb_fifo_byte_packer: drives fifo_byte_packer from a queue-based show-ahead FIFO model
// and checks emitted words against byte lists chunked into LANES-sized groups.
module tb_fifo_byte_packer;
   localparam int TIMEOUT = 16;
   localparam int LANES   = 4;
   localparam int DEPTH   = 4;
   logic        clk = 0, reset = 1, fifo_empty = 1, fifo_read, out_valid, out_ready = 0;
   logic [7:0]  fifo_read_data = 0;
   logic [31:0] out_data;
   logic [2:0]  out_count;
   int          errors = 0, checks = 0;
   logic [7:0]  src[$], q[$];
   logic [34:0] got[$];
   int          ecnt = 0, pop_total = 0, send_pops = 0, last_pop = -1, prev_pop = -1, rise = -1;
   logic        prev_v = 0, m_pop, m_push;

   fifo_byte_packer #(.FIFO_DATA_WIDTH(8), .LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
      .fifo_read(fifo_read), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_count(out_count)
   );

   always #5 clk = ~clk;

   // Edge-sampled monitor plus FIFO model; FIFO state moves 1 time unit after the edge.
   always @(posedge clk) begin
      m_pop  = fifo_read;
      m_push = (src.size() > 0) && (q.size() < DEPTH);
      if (fifo_read) begin
         pop_total++;
         prev_pop = last_pop;
         last_pop = ecnt;
      end
      if (out_valid && fifo_read) send_pops++;
      if (out_valid === 1'b1 && !prev_v) rise = ecnt;
      prev_v = (out_valid === 1'b1);
      if (out_valid && out_ready) got.push_back({out_count, out_data});
      ecnt++;
      #1;
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(src.pop_front());
      fifo_empty     = (q.size() == 0);
      fifo_read_data = fifo_empty ? 8'h00 : q[0];
   end

   function automatic logic [34:0] word_at(int i);
      return (i < got.size()) ? got[i] : 35'bx;
   endfunction

   task automatic do_reset(int cycles);
      @(negedge clk);
      reset = 1;
      out_ready = 0;
      src.delete();
      q.delete();
      got.delete();
      fifo_empty = 1;
      fifo_read_data = 0;
      repeat (cycles) @(negedge clk);
      reset = 0;
      pop_total = 0; send_pops = 0; last_pop = -1; prev_pop = -1; rise = -1;
   endtask

   task automatic wait_got(int n, int budget);
      int k = 0;
      while (got.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1;
      out_ready = 1;
      src = '{8'hA0, 8'hA1};
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (fifo_read !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || out_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: read=%b valid=%b data=%h count=%0d, want 0 0 0 0",
                     fifo_read, out_valid, out_data, out_count);
         end
      end
      reset = 0;
      #1;
      checks++;
      if (fifo_read !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_read: fifo_read=%b, want 1", fifo_read);
      end
      @(negedge clk);
      checks++;
      if (pop_total !== 1) begin
         errors++;
         $display("FAIL reset_first_pop: pops=%0d, want 1", pop_total);
      end
   endtask

   task automatic test_full_words();
      do_reset(1);
      out_ready = 1;
      for (int i = 0; i < 8; i++) src.push_back(8'(i));
      wait_got(2, 100);
      checks++;
      if (got.size() != 2) begin
         errors++;
         $display("FAIL full_count_words: got %0d words, want 2", got.size());
      end
      checks++;
      if (word_at(0) !== {3'd4, 32'h03020100}) begin
         errors++;
         $display("FAIL full_word0: got %h, want %h", word_at(0), {3'd4, 32'h03020100});
      end
      checks++;
      if (word_at(1) !== {3'd4, 32'h07060504}) begin
         errors++;
         $display("FAIL full_word1: got %h, want %h", word_at(1), {3'd4, 32'h07060504});
      end
      checks++;
      if (pop_total !== 8 || send_pops !== 0) begin
         errors++;
         $display("FAIL full_pops: pops=%0d send_pops=%0d, want 8 0", pop_total, send_pops);
      end
      checks++;
      if (rise - last_pop !== 1) begin
         errors++;
         $display("FAIL full_latency: %0d, want 1", rise - last_pop);
      end
   endtask

   task automatic test_timeout();
      do_reset(1);
      out_ready = 1;
      src = '{8'h10, 8'h11, 8'h12};
      wait_got(1, 60);
      repeat (3) @(negedge clk);
      checks++;
      if (got.size() != 1 || word_at(0) !== {3'd3, 32'h00121110}) begin
         errors++;
         $display("FAIL timeout_word: words=%0d first=%h, want 1 %h", got.size(), word_at(0), {3'd3, 32'h00121110});
      end
      checks++;
      if (rise - last_pop !== TIMEOUT + 1 || pop_total !== 3) begin
         errors++;
         $display("FAIL timeout_latency: latency=%0d pops=%0d, want %0d 3", rise - last_pop, pop_total, TIMEOUT + 1);
      end
   endtask

   task automatic test_backpressure();
      do_reset(1);
      out_ready = 0;
      for (int i = 0; i < 8; i++) src.push_back(8'h20 + 8'(i));
      repeat (10) begin
         @(negedge clk);
         if (out_valid) begin
            checks++;
            if (out_data !== 32'h23222120 || out_count !== 3'd4 || fifo_read !== 1'b0) begin
               errors++;
               $display("FAIL bp_hold: data=%h count=%0d read=%b, want 23222120 4 0", out_data, out_count, fifo_read);
            end
         end
      end
      checks++;
      if (out_valid !== 1'b1 || q.size() != DEPTH || pop_total !== 4) begin
         errors++;
         $display("FAIL bp_state: valid=%b fifo_level=%0d pops=%0d, want 1 %0d 4", out_valid, q.size(), pop_total, DEPTH);
      end
      out_ready = 1;
      wait_got(2, 100);
      checks++;
      if (word_at(0) !== {3'd4, 32'h23222120} || word_at(1) !== {3'd4, 32'h27262524}) begin
         errors++;
         $display("FAIL bp_words: got %h %h, want %h %h", word_at(0), word_at(1), {3'd4, 32'h23222120}, {3'd4, 32'h27262524});
      end
      checks++;
      if (got.size() != 2 || pop_total !== 8) begin
         errors++;
         $display("FAIL bp_totals: words=%0d pops=%0d, want 2 8", got.size(), pop_total);
      end
   endtask

   task automatic test_race();
      do_reset(1);
      out_ready = 1;
      src.push_back(8'h40);
      repeat (TIMEOUT) @(negedge clk);
      src.push_back(8'h41);
      wait_got(1, 60);
      repeat (3) @(negedge clk);
      checks++;
      if (last_pop - prev_pop !== TIMEOUT) begin
         errors++;
         $display("FAIL race_alignment: pop gap=%0d, want %0d", last_pop - prev_pop, TIMEOUT);
      end
      checks++;
      if (got.size() != 1 || word_at(0) !== {3'd2, 32'h00004140}) begin
         errors++;
         $display("FAIL race_word: words=%0d first=%h, want 1 %h", got.size(), word_at(0), {3'd2, 32'h00004140});
      end
      checks++;
      if (rise - last_pop !== TIMEOUT + 1) begin
         errors++;
         $display("FAIL race_latency: %0d, want %0d", rise - last_pop, TIMEOUT + 1);
      end
   endtask

   task automatic test_reset_mid();
      do_reset(1);
      out_ready = 1;
      src = '{8'hAA, 8'hBB};
      repeat (4) @(negedge clk);
      checks++;
      if (pop_total !== 2) begin
         errors++;
         $display("FAIL mid_pops: pops=%0d, want 2", pop_total);
      end
      reset = 1;
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < 4; i++) src.push_back(8'h30 + 8'(i));
      wait_got(1, 60);
      repeat (TIMEOUT + 5) @(negedge clk);
      checks++;
      if (got.size() != 1 || word_at(0) !== {3'd4, 32'h33323130}) begin
         errors++;
         $display("FAIL mid_word: words=%0d first=%h, want 1 %h", got.size(), word_at(0), {3'd4, 32'h33323130});
      end
   endtask

   // Random bursts with random backpressure; each burst must come out as LANES-sized chunks.
   task automatic test_random();
      logic [34:0] exp[$];
      logic [7:0]  b[$];
      int          n, base, k;
      do_reset(1);
      for (int burst = 0; burst < 8; burst++) begin
         b.delete();
         exp.delete();
         n = $urandom_range(1, 11);
         for (int i = 0; i < n; i++) b.push_back(8'($urandom));
         for (int i = 0; i < n; i += LANES) begin
            logic [31:0] d = 0;
            int c = 0;
            for (int j = i; j < n && j < i + LANES; j++) begin
               d[8*(j-i) +: 8] = b[j];
               c++;
            end
            exp.push_back({3'(c), d});
         end
         base = got.size();
         foreach (b[i]) src.push_back(b[i]);
         k = 0;
         while (got.size() < base + exp.size() && k < 400) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            k++;
         end
         checks++;
         if (got.size() != base + exp.size()) begin
            errors++;
            $display("FAIL rand_count burst %0d: words=%0d, want %0d", burst, got.size() - base, exp.size());
         end
         foreach (exp[i]) begin
            checks++;
            if (word_at(base + i) !== exp[i]) begin
               errors++;
               $display("FAIL rand_word burst %0d idx %0d: got %h, want %h", burst, i, word_at(base + i), exp[i]);
            end
         end
      end
      out_ready = 1;
   endtask

   initial begin
      test_reset();
      test_full_words();
      test_timeout();
      test_backpressure();
      test_race();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
